pipe_id_ex_stage: RTL and testbench

//  Parametrised, elastic ID->EX pipeline register for the RV32 pipelined core.
//  - Uses a valid/ready handshake with a 2-entry skid buffer, so EX back-pressure never creates a combinational ready path into ID.
//  - A synchronous flush kills in-flight instructions on branch/jump redirect.
//  - When empty, it presents a zeroed NOP payload, so EX sees no register write and no memory access.
//  - A saturating bubble counter supports performance analysis.

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_skid_buf.sv | 91 +++++++++
 rtl/pipe_id_ex_stage.sv | 124 ++++++++++++
 tb/tb_pipe_id_ex_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: ID/EX payload struct, control-word layout and skid-buffer states.
// Imported by the pipeline-register stages of the RV32 core.
package pipe_pkg;

    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int CTRLW = 12;

    // Bit positions inside the packed control word
    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMWRITE    = 1;
    localparam int CTRL_ALUSRC      = 2;
    localparam int CTRL_ALU_CTRL_LO = 3;
    localparam int CTRL_ALU_CTRL_HI = 5;
    localparam int CTRL_RESULT_LO   = 6;
    localparam int CTRL_RESULT_HI   = 7;
    localparam int CTRL_BRANCH      = 8;
    localparam int CTRL_JUMP        = 9;
    localparam int CTRL_MEMREAD     = 10;
    localparam int CTRL_SPARE       = 11;

    typedef struct packed {
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc_plus_4;
        logic [XLEN-1:0]  imm_ext;
        logic [REGW-1:0]  rd;
        logic [REGW-1:0]  rs1;
        logic [REGW-1:0]  rs2;
        logic [CTRLW-1:0] ctrl;
    } id_ex_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // True when a control word would change architectural state (register or memory write)
    function automatic logic ctrl_has_side_effect(input logic [CTRLW-1:0] ctrl);
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with synchronous flush; M drives the output, S absorbs
// the one entry accepted while EX stalls, so in_ready is a plain register.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_e state_r;
    T            m_r;
    T            s_r;
    logic        m_valid_r;
    logic        in_ready_r;
    logic        accept_s;
    logic        deliver_s;

    assign accept_s  = in_valid & in_ready_r;
    assign deliver_s = m_valid_r & out_ready;

    // Occupancy FSM; M always holds the older entry so ordering stays FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= SKID_EMPTY;
            m_r        <= '0;
            s_r        <= '0;
            m_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (flush) begin
            state_r    <= SKID_EMPTY;
            m_r        <= '0;
            s_r        <= '0;
            m_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        m_r       <= in_data;
                        m_valid_r <= 1'b1;
                        state_r   <= SKID_ONE;
                    end else begin
                        state_r   <= SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (accept_s && deliver_s) begin
                        m_r        <= in_data;
                    end else if (accept_s) begin
                        s_r        <= in_data;
                        in_ready_r <= 1'b0;
                        state_r    <= SKID_FULL;
                    end else if (deliver_s) begin
                        m_valid_r  <= 1'b0;
                        state_r    <= SKID_EMPTY;
                    end else begin
                        state_r    <= SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (deliver_s) begin
                        m_r        <= s_r;
                        in_ready_r <= 1'b1;
                        state_r    <= SKID_ONE;
                    end else begin
                        state_r    <= SKID_FULL;
                    end
                end
                default: begin
                    state_r    <= SKID_EMPTY;
                    m_valid_r  <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = m_valid_r;
    assign out_data  = m_r;

endmodule

// File: rtl/pipe_id_ex_stage.sv
// Elastic ID->EX pipeline register: packs the ID payload into a skid buffer, presents
// a zeroed NOP to EX when empty, and counts EX-side bubble cycles.
module pipe_id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int CTRLW = pipe_pkg::CTRLW,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus_4_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [REGW-1:0]  rd_d,
    input  logic [REGW-1:0]  rs1_d,
    input  logic [REGW-1:0]  rs2_d,
    input  logic [CTRLW-1:0] ctrl_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus_4_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [REGW-1:0]  rd_e,
    output logic [REGW-1:0]  rs1_e,
    output logic [REGW-1:0]  rs2_e,
    output logic [CTRLW-1:0] ctrl_e,
    output logic [CNTW-1:0]  bubble_cnt
);

    // Same field order as pipe_pkg::id_ex_t, sized by this instance's parameters
    typedef struct packed {
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc_plus_4;
        logic [XLEN-1:0]  imm_ext;
        logic [REGW-1:0]  rd;
        logic [REGW-1:0]  rs1;
        logic [REGW-1:0]  rs2;
        logic [CTRLW-1:0] ctrl;
    } stage_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    stage_t          in_pkt_s;
    stage_t          m_pkt_s;
    stage_t          ex_pkt_s;
    logic            m_valid_s;
    logic [CNTW-1:0] bubble_cnt_r;

    // Pack the ID-side fields
    always_comb begin
        in_pkt_s           = '0;
        in_pkt_s.rd1       = rd1_d;
        in_pkt_s.rd2       = rd2_d;
        in_pkt_s.pc        = pc_d;
        in_pkt_s.pc_plus_4 = pc_plus_4_d;
        in_pkt_s.imm_ext   = imm_ext_d;
        in_pkt_s.rd        = rd_d;
        in_pkt_s.rs1       = rs1_d;
        in_pkt_s.rs2       = rs2_d;
        in_pkt_s.ctrl      = ctrl_d;
    end

    pipe_skid_buf #(
        .T (stage_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pkt_s),
        .out_valid (m_valid_s),
        .out_ready (out_ready),
        .out_data  (m_pkt_s)
    );

    // An empty stage must look like a NOP to EX: no register write, no memory access
    always_comb begin
        ex_pkt_s = '0;
        if (m_valid_s) begin
            ex_pkt_s = m_pkt_s;
        end else begin
            ex_pkt_s = '0;
        end
    end

    // Saturating bubble counter; cnt_clr wins, flush leaves it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_r <= '0;
        end else if (cnt_clr) begin
            bubble_cnt_r <= '0;
        end else if (out_ready && !m_valid_s && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNTW'(1);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign out_valid   = m_valid_s;
    assign rd1_e       = ex_pkt_s.rd1;
    assign rd2_e       = ex_pkt_s.rd2;
    assign pc_e        = ex_pkt_s.pc;
    assign pc_plus_4_e = ex_pkt_s.pc_plus_4;
    assign imm_ext_e   = ex_pkt_s.imm_ext;
    assign rd_e        = ex_pkt_s.rd;
    assign rs1_e       = ex_pkt_s.rs1;
    assign rs2_e       = ex_pkt_s.rs2;
    assign ctrl_e      = ex_pkt_s.ctrl;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_id_ex_stage.sv
// Directed table plus hand sequences and a short scoreboard run for pipe_id_ex_stage.
module tb_pipe_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] pc_in = 32'd0;

    logic [31:0] rd1_d, rd2_d, pc_plus_4_d, imm_ext_d;
    logic [4:0]  rd_d, rs1_d, rs2_d;
    logic [11:0] ctrl_d;

    logic        in_ready, out_valid;
    logic [31:0] rd1_e, rd2_e, pc_e, pc_plus_4_e, imm_ext_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;
    logic [11:0] ctrl_e;
    logic [15:0] bubble_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_rd1_e, s_rd2_e, s_pc_e, s_pc_plus_4_e, s_imm_ext_e;
    logic [4:0]  s_rd_e, s_rs1_e, s_rs2_e;
    logic [11:0] s_ctrl_e;
    logic [1:0]  s_bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Every payload field is derived from the PC so one value identifies the whole packet
    assign rd1_d       = ~pc_in;
    assign rd2_d       = pc_in + 32'd1;
    assign pc_plus_4_d = pc_in + 32'd4;
    assign imm_ext_d   = {pc_in[15:0], pc_in[31:16]};
    assign rd_d        = pc_in[6:2];
    assign rs1_d       = pc_in[7:3];
    assign rs2_d       = pc_in[8:4];
    assign ctrl_d      = pc_in[11:0];

    pipe_id_ex_stage #(.XLEN(32), .REGW(5), .CTRLW(12), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_in), .pc_plus_4_d(pc_plus_4_d),
        .imm_ext_d(imm_ext_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .ctrl_d(ctrl_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e),
        .imm_ext_e(imm_ext_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .ctrl_e(ctrl_e),
        .bubble_cnt(bubble_cnt)
    );

    pipe_id_ex_stage #(.XLEN(32), .REGW(5), .CTRLW(12), .CNTW(2)) dut_small (
        .clk(clk), .reset(reset), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_in), .pc_plus_4_d(pc_plus_4_d),
        .imm_ext_d(imm_ext_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .ctrl_d(ctrl_d),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .pc_e(s_pc_e), .pc_plus_4_e(s_pc_plus_4_e),
        .imm_ext_e(s_imm_ext_e), .rd_e(s_rd_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .ctrl_e(s_ctrl_e),
        .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] pc,
                                logic e_ov, logic e_ir, logic [31:0] e_pc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic logic [191:0] exp_payload(logic v, logic [31:0] pc);
        logic [191:0] p;
        p = '0;
        if (v) p = {5'd0, ~pc, pc + 32'd1, pc, pc + 32'd4, {pc[15:0], pc[31:16]},
                    pc[6:2], pc[7:3], pc[8:4], pc[11:0]};
        return p;
    endfunction

    function automatic logic [191:0] act_payload();
        return {5'd0, rd1_e, rd2_e, pc_e, pc_plus_4_e, imm_ext_e, rd_e, rs1_e, rs2_e, ctrl_e};
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic cc,
                         input logic [31:0] pc);
        in_valid = iv; out_ready = ordy; flush = fl; cnt_clr = cc; pc_in = pc;
    endtask

    task automatic step(input logic iv, input logic ordy, input logic fl, input logic cc,
                        input logic [31:0] pc);
        drive(iv, ordy, fl, cc, pc);
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  q[$];
    logic [191:0] prev_pl;
    logic         prev_stall;
    logic         acc, dlv;

    initial begin
        // streaming
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1, 32'h104);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h108, 1'b1, 1'b1, 32'h108);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0);
        // back-pressure
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 32'h100);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 1'b0, 32'h100);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0);
        // flush from FULL with a pending input
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 1'b1, 32'h300);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h304, 1'b1, 1'b0, 32'h300);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0);
        // flush from ONE and from EMPTY discards the accept
        vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b1, 32'h400);
        vecs[14] = mk(1'b1, 1'b0, 1'b1, 32'h404, 1'b0, 1'b1, 32'h0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0);
        vecs[16] = mk(1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 32'h0);

        // reset asserted while the stage is full and ID still pushing
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_reset_bubble", 192'(bubble_cnt), 192'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
        chk("pre_reset_full_in_ready", 192'(in_ready), 192'd0);
        #2 reset = 1'b1;
        #1;
        chk("reset_out_valid", 192'(out_valid), 192'd0);
        chk("reset_in_ready", 192'(in_ready), 192'd1);
        chk("reset_payload", act_payload(), 192'd0);
        chk("reset_bubble", 192'(bubble_cnt), 192'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].iv, vecs[i].ordy, vecs[i].fl, 1'b0, vecs[i].pc);
            chk($sformatf("vec%0d_out_valid", i), 192'(out_valid), 192'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 192'(in_ready), 192'(vecs[i].e_ir));
            chk($sformatf("vec%0d_payload", i), act_payload(), exp_payload(vecs[i].e_ov, vecs[i].e_pc));
        end

        // bubble counter: clear, count, saturate, flush-immune, clear priority
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("bubble_clr", 192'(bubble_cnt), 192'd0);
        chk("bubble_small_clr", 192'(s_bubble_cnt), 192'd0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("bubble_five", 192'(bubble_cnt), 192'd5);
        chk("bubble_small_sat5", 192'(s_bubble_cnt), 192'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("bubble_six", 192'(bubble_cnt), 192'd6);
        chk("bubble_small_sat6", 192'(s_bubble_cnt), 192'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("bubble_flush_keeps", 192'(bubble_cnt), 192'd6);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("bubble_clr_priority", 192'(bubble_cnt), 192'd0);
        chk("bubble_small_clr2", 192'(s_bubble_cnt), 192'd0);

        // random traffic against a FIFO scoreboard
        prev_stall = 1'b0;
        prev_pl = '0;
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 1'b0, $urandom & 32'hFFFF_FFFC);
            @(negedge clk);
            chk("rnd_out_valid", 192'(out_valid), 192'(q.size() != 0));
            chk("rnd_in_ready", 192'(in_ready), 192'(q.size() < 2));
            if (q.size() != 0) chk("rnd_order", act_payload(), exp_payload(1'b1, q[0]));
            if (prev_stall) chk("rnd_stable", act_payload(), prev_pl);
            acc = in_valid & in_ready;
            dlv = out_valid & out_ready;
            if (dlv && q.size() != 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(pc_in);
            prev_stall = out_valid & ~out_ready & ~flush;
            prev_pl = act_payload();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
